// File: rtl/lb_cmd_dispatch.sv
// -----------------------------------------------------------------------------
// lb_cmd_dispatch
//
// LocalBus command dispatcher for the multi-port GMII top-levels. Incoming
// 64-bit commands are queued in a small FIFO. The head entry is decoded on
// its destination ID (bits [63:56]) and sent either to one of NUM_PORTS local
// port command interfaces or to the NextLocalBus daisy-chain output. The
// dispatcher honours per-destination almost-full backpressure. Dispatch is
// strictly in order, so a blocked head holds up everything behind it.
//
// Optional build macro: LB_BCAST_EN
//   When defined, destination 8'hFF is a broadcast. It issues only when every
//   local port and the Next output are ready. On issue it strobes all of them
//   together in one cycle with the same data.
//   When undefined, 8'hFF is an ordinary non-local ID and goes to Next.
//
// Ports
//   i_sys_clk                 system clock
//   i_sys_rst                 asynchronous active-high reset
//   LocalBus_command_wr       command write strobe from upstream
//   LocalBus_command[63:0]    command, [63:56] = destination port ID
//   LocalBus_allmostfull      registered FIFO almost-full to upstream
//   o_port_cmd_wr[NP-1:0]     one-hot write strobe per local port
//   o_port_cmd[63:0]          command data shared by all local ports
//   i_port_allmostfull[NP-1:0] per-port almost-full
//   NextLocalBus_command_wr   forward write strobe
//   NextLocalBus_command      forwarded command data
//   NextLocalBus_allmostfull  downstream almost-full
//   o_drop_cnt[15:0]          saturating count of commands dropped on full
//
// Dispatch FSM
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | FIFO empty, nothing to issue
//   S_ISSUE | head present; pop it if its target is ready, else go to S_WAIT
//   S_WAIT  | head blocked; pop it in the first cycle its target is ready
// -----------------------------------------------------------------------------
module lb_cmd_dispatch #(
   parameter int NUM_PORTS  = 4,
   parameter int PORT_BASE  = 0,
   parameter int FIFO_DEPTH = 16,
   parameter int AF_MARGIN  = 2
) (
   input  logic                 i_sys_clk,
   input  logic                 i_sys_rst,
   input  logic                 LocalBus_command_wr,
   input  logic [63:0]          LocalBus_command,
   output logic                 LocalBus_allmostfull,
   output logic [NUM_PORTS-1:0] o_port_cmd_wr,
   output logic [63:0]          o_port_cmd,
   input  logic [NUM_PORTS-1:0] i_port_allmostfull,
   output logic                 NextLocalBus_command_wr,
   output logic [63:0]          NextLocalBus_command,
   input  logic                 NextLocalBus_allmostfull,
   output logic [15:0]          o_drop_cnt
);

   localparam int            AW      = $clog2(FIFO_DEPTH);
   localparam int            CW      = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] AF_THR  = CW'(FIFO_DEPTH - AF_MARGIN);
   localparam logic [7:0]    BASE8   = 8'(PORT_BASE);
   localparam logic [7:0]    NUM8    = 8'(NUM_PORTS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t state_q, state_d;

   // FIFO storage and bookkeeping
   logic [63:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic           af_q, af_d;
   logic [15:0]    drop_cnt_q, drop_cnt_d;
   logic           push, pop, drop;

   // Registered dispatch outputs
   logic [NUM_PORTS-1:0] port_wr_q, port_wr_d;
   logic [63:0]          port_cmd_q, port_cmd_d;
   logic                 next_wr_q, next_wr_d;
   logic [63:0]          next_cmd_q, next_cmd_d;

   // Head decode
   logic [63:0]          head;
   logic [7:0]           dest;
   logic [7:0]           idx;
   logic                 local_hit;
   logic [NUM_PORTS-1:0] port_sel;
   logic                 tgt_ready;
`ifdef LB_BCAST_EN
   logic                 is_bcast;
`endif

   // ---------------------------------------------------------------------------
   // FIFO write side. The full test uses the occupancy before any pop in the
   // same cycle, so a write that arrives while full is dropped even if the
   // head leaves in that cycle.
   // ---------------------------------------------------------------------------
   assign push = LocalBus_command_wr && (count_q < DEPTH_C);
   assign drop = LocalBus_command_wr && (count_q == DEPTH_C);

   always_ff @(posedge i_sys_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= LocalBus_command;
      end
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      af_d       = (count_d >= AF_THR);
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // Head decode. The local range test uses 8-bit unsigned arithmetic:
   // dest >= base and (dest - base) < NUM_PORTS.
   // ---------------------------------------------------------------------------
   assign head      = mem_q[rd_ptr_q];
   assign dest      = head[63:56];
   assign idx       = dest - BASE8;
   assign local_hit = (dest >= BASE8) && (idx < NUM8);

   always_comb begin
      port_sel = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (local_hit && (idx == 8'(p))) begin
            port_sel[p] = 1'b1;
         end
      end
   end

`ifdef LB_BCAST_EN
   assign is_bcast = (dest == 8'hFF);

   always_comb begin
      if (is_bcast) begin
         tgt_ready = ~(|i_port_allmostfull) && ~NextLocalBus_allmostfull;
      end else if (local_hit) begin
         tgt_ready = ~(|(port_sel & i_port_allmostfull));
      end else begin
         tgt_ready = ~NextLocalBus_allmostfull;
      end
   end
`else
   always_comb begin
      if (local_hit) begin
         tgt_ready = ~(|(port_sel & i_port_allmostfull));
      end else begin
         tgt_ready = ~NextLocalBus_allmostfull;
      end
   end
`endif

   // ---------------------------------------------------------------------------
   // Dispatch FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Dispatch FSM: next-state logic. The decision after a pop looks at the
   // post-update occupancy, so a same-cycle write keeps the FSM in S_ISSUE.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE, S_WAIT: begin
            if (count_q == '0) begin
               state_d = S_IDLE;
            end else if (tgt_ready) begin
               state_d = (count_d != '0) ? S_ISSUE : S_IDLE;
            end else begin
               state_d = S_WAIT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Dispatch FSM: output logic. A pop in this cycle becomes a one-cycle
   // strobe on the next edge. The data registers only load when their strobe
   // fires, so they hold their last value in between.
   // ---------------------------------------------------------------------------
   always_comb begin
      pop = 1'b0;
      if ((state_q == S_ISSUE) || (state_q == S_WAIT)) begin
         pop = (count_q != '0) && tgt_ready;
      end
   end

   always_comb begin
      port_wr_d = '0;
      next_wr_d = 1'b0;
      if (pop) begin
`ifdef LB_BCAST_EN
         if (is_bcast) begin
            port_wr_d = '1;
            next_wr_d = 1'b1;
         end else begin
            port_wr_d = port_sel;
            next_wr_d = ~local_hit;
         end
`else
         port_wr_d = port_sel;
         next_wr_d = ~local_hit;
`endif
      end
      port_cmd_d = (|port_wr_d) ? head : port_cmd_q;
      next_cmd_d = next_wr_d    ? head : next_cmd_q;
   end

   // ---------------------------------------------------------------------------
   // Datapath registers. Reset clears them immediately, so a strobe that is
   // high when reset arrives drops in the same cycle.
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         af_q       <= 1'b0;
         drop_cnt_q <= '0;
         port_wr_q  <= '0;
         port_cmd_q <= '0;
         next_wr_q  <= 1'b0;
         next_cmd_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         af_q       <= af_d;
         drop_cnt_q <= drop_cnt_d;
         port_wr_q  <= port_wr_d;
         port_cmd_q <= port_cmd_d;
         next_wr_q  <= next_wr_d;
         next_cmd_q <= next_cmd_d;
      end
   end

   assign LocalBus_allmostfull    = af_q;
   assign o_port_cmd_wr           = port_wr_q;
   assign o_port_cmd              = port_cmd_q;
   assign NextLocalBus_command_wr = next_wr_q;
   assign NextLocalBus_command    = next_cmd_q;
   assign o_drop_cnt              = drop_cnt_q;

endmodule

// File: doc/lb_cmd_dispatch.md
Name: lb_cmd_dispatch

Overview:
- Parametrised LocalBus command dispatcher for the multi-port GMII top-levels.
- Accepts 64-bit LocalBus commands into an internal FIFO.
- Decodes the destination port ID and routes each command either to one of NUM_PORTS local GMII port command interfaces or to the NextLocalBus daisy-chain output.
- Honours per-destination almost-full backpressure and preserves strict command order.

Parameters:
- NUM_PORTS, 4, number of local GMII port command interfaces (1..16).
- PORT_BASE, 0, port ID of local port 0; local IDs are PORT_BASE..PORT_BASE+NUM_PORTS-1.
- FIFO_DEPTH, 16, command FIFO entries; power of 2, >=4.
- AF_MARGIN, 2, almost-full asserts when occupancy >= FIFO_DEPTH-AF_MARGIN.

Ports:
- i_sys_clk  in  1  system clock (125 MHz).
- i_sys_rst  in  1  asynchronous active-high reset.
- LocalBus_command_wr  in  1  command write strobe.
- LocalBus_command  in  64  command; [63:56] destination port ID.
- LocalBus_allmostfull  out  1  FIFO almost-full to upstream.
- o_port_cmd_wr  out  NUM_PORTS  one-hot write strobe per local port.
- o_port_cmd  out  64  command data shared by all local ports.
- i_port_allmostfull  in  NUM_PORTS  per-port almost-full.
- NextLocalBus_command_wr  out  1  forward write strobe.
- NextLocalBus_command  out  64  forwarded command.
- NextLocalBus_allmostfull  in  1  downstream almost-full.
- o_drop_cnt  out  16  saturating count of commands dropped on full FIFO.

Behaviour:
Reset values:
- i_sys_rst asserted at any time clears the FIFO pointers and occupancy immediately.
- All outputs go to 0: strobes, data, LocalBus_allmostfull, o_drop_cnt.
- A command in flight is lost; there is no partial issue after reset release.

FIFO write:
- On LocalBus_command_wr=1 with occupancy < FIFO_DEPTH, the command is stored.
- If occupancy == FIFO_DEPTH, the command is dropped and o_drop_cnt increments, saturating at 16'hFFFF.
- A write and a pop in the same cycle on a full FIFO: the write is still dropped, because the full test uses pre-pop occupancy.
- LocalBus_allmostfull is registered from post-update occupancy: 1 when occupancy >= FIFO_DEPTH-AF_MARGIN, else 0.

Decode of head entry:
- dest = head[63:56].
- Local hit when PORT_BASE <= dest <= PORT_BASE+NUM_PORTS-1; idx = dest-PORT_BASE, compared with 8-bit unsigned arithmetic.
- Otherwise the command is forwarded to Next.

Dispatch state machine (registered):
- IDLE: FIFO empty; all strobes 0. Go to ISSUE when occupancy becomes non-zero.
- ISSUE: if the target is ready, pop the head. Target ready means i_port_allmostfull[idx]==0 for a local hit, or NextLocalBus_allmostfull==0 for a forward.
  - Next cycle: assert exactly one strobe for 1 cycle, with data on o_port_cmd or NextLocalBus_command.
  - Stay in ISSUE while the FIFO is non-empty; otherwise go to IDLE.
  - If the target is not ready, go to WAIT.
- WAIT: hold the head; no strobe. Return to ISSUE on the first cycle the target is ready, sampled combinationally.

Timing and ordering:
- Throughput: 1 command/cycle when targets are ready.
- Latency: write at cycle t, strobe at t+2 minimum.
- Strict in-order dispatch; head-of-line blocking is intentional.
- Data outputs hold their last value when strobes are 0.
- Almost-full inputs are sampled only in ISSUE/WAIT; a deassert-then-reassert within WAIT is harmless.

Optional Feature:
- Macro: LB_BCAST_EN.
- Defined: dest==8'hFF is broadcast.
  - Issue requires all i_port_allmostfull==0 and NextLocalBus_allmostfull==0; otherwise go to WAIT.
  - On issue, all o_port_cmd_wr bits and NextLocalBus_command_wr assert together for 1 cycle with identical data.
- Undefined: 8'hFF is an ordinary non-local ID and is forwarded to Next only. No broadcast logic is synthesised.

Test Plan:
- Reset/defaults: assert i_sys_rst for 3 cycles -> all outputs 0, LocalBus_allmostfull=0, o_drop_cnt=0.
- Routing: PORT_BASE=4, NUM_PORTS=4; write dest 8'h05 then 8'h09 back-to-back -> o_port_cmd_wr=4'b0010 at t+2, then NextLocalBus_command_wr=1 at t+3, data unchanged.
- Backpressure/order: hold i_port_allmostfull[0]=1; write dest 4, then 5 -> no strobes. Release at cycle 10 -> port0 strobe at 11, port1 at 12.
- Full/drop: block all targets; write 18 commands with FIFO_DEPTH=16.
  - LocalBus_allmostfull=1 after the 14th write.
  - o_drop_cnt=2.
  - After release, exactly 16 commands are issued in order.
- Reset mid-operation: 5 queued, 2 issued, assert i_sys_rst -> strobes drop same cycle; after release no further strobes and occupancy is 0.
- Broadcast (LB_BCAST_EN): write dest 8'hFF with port2 almost-full -> wait. Release -> o_port_cmd_wr=4'b1111 and NextLocalBus_command_wr=1 in one cycle.
  - Without the macro, the same write gives a Next strobe only.
